// File: rtl/edge_pulse_array.sv
// edge_pulse_array: per-channel synchronizer, optional debounce filter,
// edge-pulse generator and sticky event flag for raw asynchronous inputs.
// Build option: define EDGE_PULSE_DEBOUNCE_EN to compile in the debounce
// counters; without it the filtered level follows the synchronizer output
// every clock.
module edge_pulse_array #(
   parameter int WIDTH       = 1,
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 4,
   parameter int EDGE_MODE   = 0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] clr,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] p,
   output logic [WIDTH-1:0] evt
);

   // Reject illegal configurations at elaboration time.
   if (WIDTH < 1 || SYNC_STAGES < 2 || DB_CYCLES < 1 ||
       EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_param
      $error("edge_pulse_array: illegal parameter combination");
   end

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] level_q, level_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0] evt_q, evt_d;
   logic [WIDTH-1:0] rise, fall;

   // Synchronizer chain: stage 0 captures the raw input, last stage is y.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= s;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign y = sync_q[SYNC_STAGES-1];

`ifdef EDGE_PULSE_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];

   // Debounce: accept y only after it has differed from level for
   // DB_CYCLES consecutive edges; any agreement restarts the count.
   always_comb begin
      level_d = level_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (y[i] != level_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               level_d[i] = y[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Debounce counter registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end
`else
   // Without debounce the level simply follows the synchronizer output.
   always_comb begin
      level_d = y;
   end
`endif

   // Edge detection on the accepted level, mode filter and sticky flag.
   always_comb begin
      rise = level_d & ~level_q;
      fall = ~level_d & level_q;
      p_d  = '0;
      if (EDGE_MODE == 0) begin
         p_d = rise;
      end else if (EDGE_MODE == 1) begin
         p_d = fall;
      end else begin
         p_d = rise | fall;
      end
      // A new pulse overrides a simultaneous clear.
      evt_d = p_d | (evt_q & ~clr);
   end

   // Output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         level_q <= '0;
         p_q     <= '0;
         evt_q   <= '0;
      end else begin
         level_q <= level_d;
         p_q     <= p_d;
         evt_q   <= evt_d;
      end
   end

   assign level = level_q;
   assign p     = p_q;
   assign evt   = evt_q;

endmodule

// File: tb/tb_edge_pulse_array.sv
// tb_edge_pulse_array: three instances (rising, falling, both edges) share
// one stimulus; a window-based reference model predicts level, p and evt.
module tb_edge_pulse_array;

   localparam int WIDTH = 4;
   localparam int SYNC  = 2;
   localparam int DB    = 4;
`ifdef EDGE_PULSE_DEBOUNCE_EN
   localparam int DBW = DB;
`else
   localparam int DBW = 1;
`endif

   logic             clk = 1'b0;
   logic             rstn;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] lvl_o [3];
   logic [WIDTH-1:0] p_o   [3];
   logic [WIDTH-1:0] evt_o [3];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   edge_pulse_array #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DB_CYCLES(DB), .EDGE_MODE(0)) u_m0 (
      .clk(clk), .rstn(rstn), .s(s), .clr(clr),
      .level(lvl_o[0]), .p(p_o[0]), .evt(evt_o[0]));

   edge_pulse_array #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DB_CYCLES(DB), .EDGE_MODE(1)) u_m1 (
      .clk(clk), .rstn(rstn), .s(s), .clr(clr),
      .level(lvl_o[1]), .p(p_o[1]), .evt(evt_o[1]));

   edge_pulse_array #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DB_CYCLES(DB), .EDGE_MODE(2)) u_m2 (
      .clk(clk), .rstn(rstn), .s(s), .clr(clr),
      .level(lvl_o[2]), .p(p_o[2]), .evt(evt_o[2]));

   // Reference model: a delay line of input samples, and a history of the
   // last DBW synchronized samples. A channel's level flips when every sample
   // in that window disagrees with the current level.
   logic [WIDTH-1:0] msh [SYNC];
   logic [WIDTH-1:0] myh [DB];
   logic [WIDTH-1:0] mlevel;
   logic [WIDTH-1:0] mp   [3];
   logic [WIDTH-1:0] mevt [3];

   task automatic model_reset();
      for (int k = 0; k < SYNC; k++) msh[k] = '0;
      for (int k = 0; k < DB; k++) myh[k] = '0;
      mlevel = '0;
      for (int m = 0; m < 3; m++) begin
         mp[m]   = '0;
         mevt[m] = '0;
      end
   endtask

   task automatic model_edge();
      logic [WIDTH-1:0] y, chg, rise, fall;
      if (!rstn) begin
         model_reset();
         return;
      end
      y = msh[SYNC-1];
      for (int k = SYNC-1; k > 0; k--) msh[k] = msh[k-1];
      msh[0] = s;
      for (int k = DBW-1; k > 0; k--) myh[k] = myh[k-1];
      myh[0] = y;
      chg = '1;
      for (int k = 0; k < DBW; k++) chg = chg & (myh[k] ^ mlevel);
      rise   = chg & ~mlevel;
      fall   = chg & mlevel;
      mlevel = mlevel ^ chg;
      mp[0] = rise;
      mp[1] = fall;
      mp[2] = rise | fall;
      for (int m = 0; m < 3; m++) mevt[m] = mp[m] | (mevt[m] & ~clr);
   endtask

   task automatic check();
      for (int m = 0; m < 3; m++) begin
         n_cmp++;
         assert (lvl_o[m] === mlevel) else begin
            n_bad++;
            $error("FAIL level_mode%0d: observed %b expected %b", m, lvl_o[m], mlevel);
         end
         n_cmp++;
         assert (p_o[m] === mp[m]) else begin
            n_bad++;
            $error("FAIL pulse_mode%0d: observed %b expected %b", m, p_o[m], mp[m]);
         end
         n_cmp++;
         assert (evt_o[m] === mevt[m]) else begin
            n_bad++;
            $error("FAIL evt_mode%0d: observed %b expected %b", m, evt_o[m], mevt[m]);
         end
      end
   endtask

   // One clock edge: advance the model with the inputs held at the edge,
   // then sample the DUTs shortly after the edge.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check();
   endtask

   initial begin
      rstn = 1'b0;
      s    = '0;
      clr  = '0;
      model_reset();
      #1;
      check();
      repeat (2) step();

      // Input high through reset release: one rising pulse after release.
      s = 4'b0001;
      repeat (2) step();
      rstn = 1'b1;
      repeat (10) step();

      // Multi-channel simultaneous edges.
      s = 4'b0000;
      repeat (10) step();
      s = 4'b0101;
      repeat (10) step();
      s = 4'b1010;
      repeat (10) step();

      // Short glitch on channel 0.
      s = 4'b0000;
      repeat (10) step();
      s = 4'b0001;
      repeat (3) step();
      s = 4'b0000;
      repeat (10) step();

      // Clear all flags, then hold clear on channel 0 across a new pulse.
      clr = '1;
      step();
      clr = '0;
      step();
      clr = 4'b0001;
      s   = 4'b0001;
      repeat (10) step();
      s   = 4'b0000;
      repeat (10) step();
      clr = '0;

      // Reset asserted mid-debounce, input withdrawn before release.
      s = 4'b1111;
      repeat (3) step();
      rstn = 1'b0;
      s    = 4'b0000;
      model_reset();
      #1;
      check();
      repeat (2) step();
      rstn = 1'b1;
      repeat (12) step();

      // Randomized levels, glitches and clears.
      repeat (400) begin
         if ($urandom_range(0, 5) == 0) s = WIDTH'($urandom);
         clr = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom) : '0;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
